// File: rtl/if_id_stage_buffer_pkg.sv
// Shared IF/ID pipeline definitions: field width, bubble constants and the
// bundle consumed by the decode stage.
package if_id_stage_buffer_pkg;

  localparam int unsigned IF_ID_DATA_W = 32;

  localparam logic [IF_ID_DATA_W-1:0] IF_ID_NOP_INSTR = 32'h0000_0000;
  localparam logic [IF_ID_DATA_W-1:0] IF_ID_PC_RESET  = 32'h0000_0000;

  typedef struct packed {
    logic [IF_ID_DATA_W-1:0] ins;
    logic [IF_ID_DATA_W-1:0] pc_4;
    logic                    valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble();
    if_id_t w_b;
    w_b.ins   = IF_ID_NOP_INSTR;
    w_b.pc_4  = IF_ID_PC_RESET;
    w_b.valid = 1'b0;
    return w_b;
  endfunction

endpackage

// File: rtl/if_id_stage_buffer_pipe_reg_en.sv
// Generic pipeline register: async active-high reset, synchronous clear,
// load enable; clear takes priority over load.
module pipe_reg_en #(
  parameter int unsigned    W       = 32,
  parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Storage element with reset/clear/load/hold priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (i_clr) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_id_stage_buffer.sv
// IF/ID stage buffer: captures instruction and PC+4 on write-enable, holds on
// stall, injects a NOP bubble on flush. Outputs come straight from flops.
module if_id_stage_buffer
  import if_id_stage_buffer_pkg::*;
#(
  parameter int unsigned         DATA_W    = IF_ID_DATA_W,
  parameter logic [DATA_W-1:0]   NOP_INSTR = IF_ID_NOP_INSTR,
  parameter logic [DATA_W-1:0]   PC_RESET  = IF_ID_PC_RESET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_4_in,
  input  logic [DATA_W-1:0] ins_in,
  input  logic              if_id_reg_ctrl,
  input  logic              if_id_flush,
  output logic [DATA_W-1:0] if_id_ins_out,
  output logic [DATA_W-1:0] if_id_pc_4_out,
  output logic              if_id_valid_out
);

  logic w_clr;
  logic w_load;

  // Flush overrides the write enable; a flushed cycle never loads new data
  always_comb begin
    w_clr  = 1'b0;
    w_load = 1'b0;
    if (if_id_flush) begin
      w_clr  = 1'b1;
      w_load = 1'b0;
    end else begin
      w_clr  = 1'b0;
      w_load = if_id_reg_ctrl;
    end
  end

  pipe_reg_en #(
    .W       (DATA_W),
    .RST_VAL (NOP_INSTR)
  ) u_ins_reg (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_load),
    .i_d   (ins_in),
    .o_q   (if_id_ins_out)
  );

  pipe_reg_en #(
    .W       (DATA_W),
    .RST_VAL (PC_RESET)
  ) u_pc_4_reg (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_load),
    .i_d   (pc_4_in),
    .o_q   (if_id_pc_4_out)
  );

  pipe_reg_en #(
    .W       (1),
    .RST_VAL (1'b0)
  ) u_valid_reg (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_load),
    .i_d   (1'b1),
    .o_q   (if_id_valid_out)
  );

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Directed, table-driven bench for the IF/ID stage buffer.
module tb_if_id_stage_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_4_in;
  logic [31:0] ins_in;
  logic        if_id_reg_ctrl;
  logic        if_id_flush;
  logic [31:0] if_id_ins_out;
  logic [31:0] if_id_pc_4_out;
  logic        if_id_valid_out;

  int n_checks = 0;
  int n_errors = 0;

  if_id_stage_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .pc_4_in         (pc_4_in),
    .ins_in          (ins_in),
    .if_id_reg_ctrl  (if_id_reg_ctrl),
    .if_id_flush     (if_id_flush),
    .if_id_ins_out   (if_id_ins_out),
    .if_id_pc_4_out  (if_id_pc_4_out),
    .if_id_valid_out (if_id_valid_out)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        ctrl;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] exp_ins;
    logic [31:0] exp_pc;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_ins,
                           input logic [31:0] e_pc, input logic e_v);
    check({tag, ".ins"}, if_id_ins_out, e_ins);
    check({tag, ".pc4"}, if_id_pc_4_out, e_pc);
    check({tag, ".valid"}, {31'd0, if_id_valid_out}, {31'd0, e_v});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd1,        32'd3,        32'd3,        32'd1,        1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'd5,        32'd7,        32'd3,        32'd1,        1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'd5,        32'd7,        32'd3,        32'd1,        1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h8,        32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h8,       1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'hC,        32'h5555_5555, 32'h5555_5555, 32'hC,       1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'd1,        32'd3,        32'd3,        32'd1,        1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h44,       32'hDEAD_BEEF, 32'h0,        32'h0,        1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h48,       32'h1234_5678, 32'h0,        32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h4C,       32'h1111_2222, 32'h0,        32'h0,        1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'd1,        32'd3,        32'd3,        32'd1,        1'b1};

    // Reset asserted at time zero with live-looking inputs
    rst = 1'b1; pc_4_in = 32'd9; ins_in = 32'd9;
    if_id_reg_ctrl = 1'b1; if_id_flush = 1'b0;
    #1 check_all("reset_t1", 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1 check_all("reset_e1", 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1 check_all("reset_e2", 32'd0, 32'd0, 1'b0);

    @(negedge clk);
    rst = 1'b0; if_id_reg_ctrl = 1'b0;
    @(posedge clk); #1 check_all("post_rst_hold", 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if_id_flush = vecs[i].flush; if_id_reg_ctrl = vecs[i].ctrl;
      pc_4_in = vecs[i].pc; ins_in = vecs[i].ins;
      @(posedge clk); #1
      check_all($sformatf("vec%0d", i), vecs[i].exp_ins, vecs[i].exp_pc, vecs[i].exp_valid);
    end

    // Input changes between edges must not reach the outputs
    @(negedge clk);
    if_id_reg_ctrl = 1'b1; ins_in = 32'hCAFE_F00D; pc_4_in = 32'h100;
    #10 ins_in = 32'h0BAD_0BAD;
    #10 check_all("no_comb_path", 32'd3, 32'd1, 1'b1);
    @(posedge clk); #1 check_all("last_value_wins", 32'h0BAD_0BAD, 32'h100, 1'b1);

    // Long stall keeps contents
    @(negedge clk);
    if_id_reg_ctrl = 1'b0; ins_in = 32'h7777_7777; pc_4_in = 32'h200;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1 check_all("long_stall", 32'h0BAD_0BAD, 32'h100, 1'b1);
    end

    // Reload 1/3, then async reset pulse between edges
    @(negedge clk);
    if_id_reg_ctrl = 1'b1; ins_in = 32'd3; pc_4_in = 32'd1;
    @(posedge clk); #1 check_all("reload", 32'd3, 32'd1, 1'b1);
    #20 ins_in = 32'h9999_9999; pc_4_in = 32'h50;
    rst = 1'b1;
    #5 check_all("async_rst", 32'd0, 32'd0, 1'b0);
    #5 rst = 1'b0;
    #5 check_all("rst_released_noedge", 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1 check_all("load_after_rst", 32'h9999_9999, 32'h50, 1'b1);

    // Flush alone while holding produces a bubble
    @(negedge clk);
    if_id_reg_ctrl = 1'b0; if_id_flush = 1'b1;
    @(posedge clk); #1 check_all("flush_on_stall", 32'd0, 32'd0, 1'b0);

    @(negedge clk);
    if_id_flush = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage_buffer.md
Name: if_id_stage_buffer

Overview:
- Pipeline stage buffer between Instruction Fetch and Instruction Decode of the 32-bit RISC-style core.
- Captures the fetched instruction and its PC+4 on the rising clock edge when the write-control is asserted.
- Holds its contents when write-control is deasserted (stall).
- Supports a synchronous flush that injects a NOP bubble; an asynchronous reset clears the stage.

Parameters:
- DATA_W, 32, width of the instruction and PC+4 fields.
- NOP_INSTR, 32'h0000_0000, instruction word loaded on reset and on flush.
- PC_RESET, 32'h0000_0000, PC+4 value loaded on reset and on flush.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- pc_4_in  input  DATA_W  PC+4 from the IF stage.
- ins_in  input  DATA_W  fetched instruction from the IF stage.
- if_id_reg_ctrl  input  1  write enable: 1 = load new values, 0 = hold (stall).
- if_id_flush  input  1  synchronous flush: 1 = load bubble.
- if_id_ins_out  output  DATA_W  registered instruction to the ID stage.
- if_id_pc_4_out  output  DATA_W  registered PC+4 to the ID stage.
- if_id_valid_out  output  1  1 = stage holds a real fetched instruction; 0 = bubble.

Behaviour:
- Reset
  - On rst=1, immediately and independent of clk: if_id_ins_out=NOP_INSTR, if_id_pc_4_out=PC_RESET, if_id_valid_out=0.
  - Outputs stay at these values while rst is held high.
  - Deassertion of rst takes effect at the next rising edge.
  - Reset asserted mid-operation discards any pending load.
- At each rising edge with rst=0, the following priority applies:
  1. if_id_flush=1: load NOP_INSTR, PC_RESET and valid=0. Flush wins over if_id_reg_ctrl, whatever its value.
  2. if_id_reg_ctrl=1: if_id_ins_out<=ins_in, if_id_pc_4_out<=pc_4_in, if_id_valid_out<=1.
  3. Otherwise all outputs hold their previous values.
- Latency: exactly one clock edge from input to output.
- No combinational path from any input to any output.
- Input changes between edges have no effect on the outputs.
- All fields are pure storage: no arithmetic and no width conversion. Inputs pass through bit-exact.
- Control inputs: if_id_reg_ctrl and if_id_flush are sampled only at the rising edge.
- A stall lasting any number of cycles preserves the contents indefinitely.
- X-handling: control inputs are assumed driven after reset. No defined behaviour is required for X on the controls.

Decomposition:
- Shared pipeline package holds:
  - the DATA_W default (32);
  - the NOP_INSTR constant;
  - a packed struct typedef if_id_t {ins, pc_4, valid}, so the ID stage consumes one bundle.
- One natural sub-module: pipe_reg_en, a parameterised-width register with async active-high reset value, synchronous clear and load enable.
  - It is instantiated once per field, or once on the packed struct.
  - The top level only resolves flush/enable priority.

Test Plan:
1. Reset: assert rst=1 at t=0 with inputs pc_4_in=32'd9, ins_in=32'd9 and if_id_reg_ctrl=1 → outputs are 0/0/valid=0 immediately, before any clock edge, and remain so across edges while rst=1.
2. Load: rst=0, clk period 100 (rising edges at 50, 150, 250); at t=100 set if_id_reg_ctrl=1, pc_4_in=1, ins_in=3 → after the edge at 150, if_id_pc_4_out=1, if_id_ins_out=3, valid=1.
3. Stall: continuing 2, at t=200 set if_id_reg_ctrl=0, pc_4_in=5, ins_in=7 → after the edges at 250, 350 and later, outputs remain 1/3/valid=1.
4. Back-to-back loads: if_id_reg_ctrl=1 with ins_in=0xAAAA_AAAA then 0x5555_5555 on consecutive edges → outputs track with exactly one-cycle latency, bit-exact.
5. Flush priority: contents 1/3; assert if_id_flush=1 and if_id_reg_ctrl=1 with ins_in=0xDEAD_BEEF → after the edge, outputs are NOP_INSTR/PC_RESET/valid=0; the new data is not captured.
6. Async reset mid-cycle: with contents 1/3/1, pulse rst between edges → outputs clear to 0/0/0 without waiting for a clock edge; the next load after release captures normally.
